// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and the width helper used for pointer and occupancy sizing.
package fifo_pkg;

  localparam int DEFAULT_DATA_W = 6;
  localparam int DEFAULT_DEPTH  = 8;

  // Smallest r with 2**r >= n; elaboration-time only.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage, one write port, one registered read port; 1-cycle read latency.
// No backpressure here: the controller decides which accesses happen.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int AW     = clog2(DEFAULT_DEPTH)
) (
  input  logic              clk,
  input  logic              RESET_L,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage deliberately has no reset; only words already written are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  // Same-address read+write (full with both accepted) returns the old word.
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L)   rd_dat <= '0;
    else if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_param.sv
// Synchronous FIFO with status flags and sticky errors; read data one clock after accepted read.
// Writes dropped when full without a same-cycle read; reads ignored when empty.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int AF_TH  = DEPTH - 2,
  parameter int AE_TH  = 2
) (
  input  logic                  clk,
  input  logic                  RESET_L,
  input  logic                  fifo_wr,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  fifo_rd,
  input  logic                  err_clr,
  output logic [DATA_W-1:0]     data_out,
  output logic                  data_valid,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [clog2(DEPTH):0] fifo_count,
  output logic                  err_full,
  output logic                  err_empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_TH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_TH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_go, rd_go, ovf_evt, unf_evt;

  // A read frees a slot in the same cycle, so a full FIFO still takes the write.
  assign rd_go   = fifo_rd && !fifo_empty;
  assign wr_go   = fifo_wr && (!fifo_full || rd_go);
  assign ovf_evt = fifo_wr && fifo_full && !rd_go;
  assign unf_evt = fifo_rd && fifo_empty && !fifo_wr;

  // Flags decode the registered count only.
  assign fifo_empty   = (fifo_count == '0);
  assign fifo_full    = (fifo_count == FULL_CNT);
  assign almost_empty = (fifo_count <= AE_CNT);
  assign almost_full  = (fifo_count >= AF_CNT);

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      data_valid <= 1'b0;
      err_full   <= 1'b0;
      err_empty  <= 1'b0;
    end else begin
      if (wr_go) wr_ptr <= wr_ptr + AW'(1);
      if (rd_go) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_go, rd_go})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      data_valid <= rd_go;
      // A fresh error in the clearing cycle keeps the flag set.
      err_full  <= ovf_evt || (err_full  && !err_clr);
      err_empty <= unf_evt || (err_empty && !err_clr);
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .RESET_L (RESET_L),
    .wr_en   (wr_go),
    .wr_addr (wr_ptr),
    .wr_dat  (data_in),
    .rd_en   (rd_go),
    .rd_addr (rd_ptr),
    .rd_dat  (data_out)
  );

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param: queue reference model, directed cases then random traffic.
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       fifo_wr = 1'b0, fifo_rd = 1'b0, err_clr = 1'b0;
  logic [5:0] data_in = '0;
  logic [5:0] data_out;
  logic       data_valid, fifo_empty, fifo_full, almost_empty, almost_full;
  logic [3:0] fifo_count;
  logic       err_full, err_empty;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] model_q[$];
  logic [5:0] exp_q[$];
  logic       m_err_full = 1'b0, m_err_empty = 1'b0;
  logic [5:0] m_last = '0;

  always #5 clk = ~clk;

  fifo_param #(.DATA_W(6), .DEPTH(8), .AF_TH(6), .AE_TH(2)) dut (
    .clk          (clk),
    .RESET_L      (rst_l),
    .fifo_wr      (fifo_wr),
    .data_in      (data_in),
    .fifo_rd      (fifo_rd),
    .err_clr      (err_clr),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .fifo_count   (fifo_count),
    .err_full     (err_full),
    .err_empty    (err_empty)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every data_valid pulse must match the oldest expected read.
  always @(posedge clk) begin
    #1;
    if (data_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        chk("read_data", int'(data_out), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic chk_status(input string tag);
    int n;
    n = model_q.size();
    chk({tag, ":count"}, int'(fifo_count), n);
    chk({tag, ":empty"}, int'(fifo_empty), int'(n == 0));
    chk({tag, ":full"}, int'(fifo_full), int'(n == 8));
    chk({tag, ":almost_empty"}, int'(almost_empty), int'(n <= 2));
    chk({tag, ":almost_full"}, int'(almost_full), int'(n >= 6));
    chk({tag, ":err_full"}, int'(err_full), int'(m_err_full));
    chk({tag, ":err_empty"}, int'(err_empty), int'(m_err_empty));
    chk({tag, ":data_out_hold"}, int'(data_out), int'(m_last));
  endtask

  // One clock of stimulus; the model applies the FIFO rules to its queue.
  task automatic step(input logic wr, input logic [5:0] d, input logic rd, input logic clr,
                      input string tag);
    logic rd_acc, wr_acc, ovf, unf;
    @(negedge clk);
    fifo_wr = wr; data_in = d; fifo_rd = rd; err_clr = clr;
    rd_acc = rd && (model_q.size() > 0);
    wr_acc = wr && (model_q.size() < 8 || rd_acc);
    ovf    = wr && (model_q.size() == 8) && !rd_acc;
    unf    = rd && (model_q.size() == 0) && !wr;
    if (rd_acc) begin
      m_last = model_q.pop_front();
      exp_q.push_back(m_last);
    end
    if (wr_acc) model_q.push_back(d);
    m_err_full  = ovf || (m_err_full && !clr);
    m_err_empty = unf || (m_err_empty && !clr);
    @(posedge clk);
    #1;
    fifo_wr = 1'b0; fifo_rd = 1'b0; err_clr = 1'b0;
    chk({tag, ":data_valid"}, int'(data_valid), int'(rd_acc));
    chk_status(tag);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ":count"}, int'(fifo_count), 0);
    chk({tag, ":empty"}, int'(fifo_empty), 1);
    chk({tag, ":almost_empty"}, int'(almost_empty), 1);
    chk({tag, ":full"}, int'(fifo_full), 0);
    chk({tag, ":almost_full"}, int'(almost_full), 0);
    chk({tag, ":data_out"}, int'(data_out), 0);
    chk({tag, ":data_valid"}, int'(data_valid), 0);
    chk({tag, ":err_full"}, int'(err_full), 0);
    chk({tag, ":err_empty"}, int'(err_empty), 0);
  endtask

  initial begin
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_l = 1'b1;

    // Single word round trip
    step(1'b1, 6'b010010, 1'b0, 1'b0, "single_wr");
    step(1'b0, 6'd0, 1'b1, 1'b0, "single_rd");
    step(1'b0, 6'd0, 1'b0, 1'b0, "single_idle");

    // Fill, overflow, drain
    for (int i = 0; i < 8; i++) step(1'b1, 6'(i), 1'b0, 1'b0, "fill");
    step(1'b1, 6'd63, 1'b0, 1'b0, "overflow");
    step(1'b0, 6'd0, 1'b0, 1'b1, "clr_full");
    for (int i = 0; i < 8; i++) step(1'b0, 6'd0, 1'b1, 1'b0, "drain");

    // Full with simultaneous read and write, then drain across the wrap
    for (int i = 0; i < 8; i++) step(1'b1, 6'(i), 1'b0, 1'b0, "fill2");
    step(1'b1, 6'b111111, 1'b1, 1'b0, "full_rdwr");
    for (int i = 0; i < 8; i++) step(1'b0, 6'd0, 1'b1, 1'b0, "drain2");

    // Underflow and sticky clear behaviour
    step(1'b0, 6'd0, 1'b1, 1'b0, "underflow");
    step(1'b0, 6'd0, 1'b0, 1'b0, "uf_sticky");
    step(1'b0, 6'd0, 1'b0, 1'b1, "uf_clr");
    step(1'b0, 6'd0, 1'b1, 1'b1, "uf_clr_collide");
    step(1'b0, 6'd0, 1'b0, 1'b1, "uf_clr2");

    // Empty with simultaneous read and write
    step(1'b1, 6'b000101, 1'b1, 1'b0, "empty_rdwr");
    step(1'b0, 6'd0, 1'b1, 1'b0, "empty_rdwr_rd");

    // Asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) step(1'b1, 6'(20 + i), 1'b0, 1'b0, "pre_reset");
    @(posedge clk);
    #2;
    rst_l = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    model_q.delete();
    m_err_full = 1'b0; m_err_empty = 1'b0; m_last = '0;
    @(negedge clk);
    rst_l = 1'b1;
    step(1'b1, 6'd33, 1'b0, 1'b0, "post_reset_wr");
    step(1'b0, 6'd0, 1'b1, 1'b0, "post_reset_rd");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 55, 6'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 5, "rand");
    end

    step(1'b0, 6'd0, 1'b0, 1'b0, "final_idle");
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter DATA_W, default 6, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, number of storage words (power of two, >=4).
REQ-003 Parameter AF_TH, default DEPTH-2, almost_full threshold in words.
REQ-004 Parameter AE_TH, default 2, almost_empty threshold in words.
REQ-005 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 Port RESET_L  input  1  asynchronous, active-low reset.
REQ-007 Port fifo_wr  input  1  write request.
REQ-008 Port data_in  input  DATA_W  write data, sampled with fifo_wr.
REQ-009 Port fifo_rd  input  1  read request.
REQ-010 Port err_clr  input  1  clears sticky error flags.
REQ-011 Port data_out  output  DATA_W  registered read data.
REQ-012 Port data_valid  output  1  one-cycle pulse: data_out holds newly read word.
REQ-013 Port fifo_empty / fifo_full  output  1 each  occupancy 0 / occupancy DEPTH.
REQ-014 Port almost_empty / almost_full  output  1 each  count<=AE_TH / count>=AF_TH.
REQ-015 Port fifo_count  output  log2(DEPTH)+1  current occupancy.
REQ-016 Port err_full / err_empty  output  1 each  sticky overflow / underflow flags.

Function
REQ-017 Write accepted when fifo_wr=1 and (fifo_full=0 or accepted read in same cycle); word stored at write pointer.
REQ-018 Read accepted when fifo_rd=1 and fifo_empty=0; word at read pointer loaded into data_out at that edge, data_valid=1 for exactly the following cycle.
REQ-019 Read latency: data_out/data_valid valid one clock after the edge where fifo_rd sampled high; no fall-through when empty.
REQ-020 data_out holds its last value when no read is accepted.
REQ-021 Pointers increment modulo DEPTH; wrap-around transparent to data order (strict FIFO order).
REQ-022 fifo_count: +1 on write only, -1 on read only, unchanged on both or neither; never exceeds DEPTH or drops below 0.
REQ-023 Full with simultaneous rd+wr: both accepted, count stays DEPTH, fifo_full stays 1.
REQ-024 Empty with simultaneous rd+wr: write accepted, read ignored, no underflow error, count becomes 1, data_valid stays 0.
REQ-025 Overflow: fifo_wr=1, fifo_full=1, no accepted read -> data dropped, contents unchanged, err_full set next edge.
REQ-026 Underflow: fifo_rd=1, fifo_empty=1, fifo_wr=0 -> nothing read, err_empty set next edge.
REQ-027 err_full/err_empty stay set until err_clr=1 at an edge; new error in same cycle as err_clr wins (flag remains 1).
REQ-028 All status flags decode from registered count; they update on the same edge as fifo_count, no combinational path from inputs.

Reset
REQ-029 RESET_L low asynchronously forces: pointers=0, fifo_count=0, fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0, data_out=0, data_valid=0, err_full=0, err_empty=0.
REQ-030 Storage array not reset; contents undefined after reset and never observable before being written.
REQ-031 Reset mid-operation discards all stored words; first edge with RESET_L high operates normally.

Structure
REQ-032 Shared package fifo_pkg holds default DATA_W/DEPTH constants and a clog2 function used for pointer and count widths.
REQ-033 Sub-module fifo_mem: DEPTH x DATA_W register array, one write port, one registered read port; control, pointers, count and flags live in fifo_param.

Verification (DATA_W=6, DEPTH=8, AF_TH=6, AE_TH=2)
REQ-034 Reset, write 6'b010010, read next cycle -> data_out=6'b010010 with data_valid pulse one clock after read; empty=1 afterwards.
REQ-035 Write 8 words 0..7 -> full=1, almost_full asserted at count 6, count=8; 9th write -> err_full=1, contents unchanged; 8 reads return 0..7 in order.
REQ-036 Fill to 8, then rd+wr same cycle with 6'b111111 -> count stays 8; drain returns 1..7 then 6'b111111 (wrap verified).
REQ-037 Empty, fifo_rd=1 alone -> err_empty=1, data_valid=0; err_clr pulse -> err_empty=0; err_clr coincident with new underflow -> err_empty stays 1.
REQ-038 Empty, rd+wr same cycle with 6'b000101 -> count=1, no error, no data_valid; next read returns 6'b000101.
REQ-039 RESET_L low mid-burst with count=5 -> all outputs at REQ-029 values immediately, before next clk edge.
